// File: rtl/dshot_frame_rx.sv
// DShot600 frame receiver: pulse-width bit decoding, 16-bit frame assembly,
// CRC check, throttle-to-speed mapping and a loss-of-signal failsafe.
module dshot_frame_rx #(
    parameter int unsigned BIT_THRESH      = 15,
    parameter int unsigned HIGH_MIN        = 4,
    parameter int unsigned HIGH_MAX        = 24,
    parameter int unsigned GAP_CYCLES      = 40,
    parameter int unsigned FAILSAFE_CYCLES = 1600000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dshotPin,
    output logic [10:0] throttle,
    output logic        telem,
    output logic [7:0]  outputSpeed,
    output logic        frame_valid,
    output logic        crc_err,
    output logic        link_ok
);

    localparam int unsigned FS_W = $clog2(FAILSAFE_CYCLES + 1);

    localparam logic [7:0]      THRESH_C = 8'(BIT_THRESH);
    localparam logic [7:0]      HMIN_C   = 8'(HIGH_MIN);
    localparam logic [7:0]      HMAX_C   = 8'(HIGH_MAX);
    localparam logic [7:0]      GAP_C    = 8'(GAP_CYCLES);
    localparam logic [FS_W-1:0] FS_LOAD  = FS_W'(FAILSAFE_CYCLES);
    localparam logic [FS_W-1:0] FS_ONE   = FS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_RESYNC,
        S_CHECK
    } state_t;

    logic        meta;
    logic        pin_s;
    logic        pin_d;
    logic        rise;
    logic        fall;

    state_t      state;
    state_t      state_n;
    logic [7:0]  hcnt;
    logic [7:0]  hcnt_n;
    logic [7:0]  lcnt;
    logic [7:0]  lcnt_n;
    logic [4:0]  bcnt;
    logic [4:0]  bcnt_n;
    logic [15:0] shreg;
    logic [15:0] shreg_n;

    logic [10:0]     rx_throttle;
    logic            rx_telem;
    logic [11:0]     rx_v;
    logic [3:0]      rx_crc;
    logic [3:0]      calc_crc;
    logic            crc_ok;
    logic [10:0]     speed_diff;
    logic [7:0]      speed_new;
    logic [FS_W-1:0] fs_cnt;

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            pin_s <= 1'b0;
            pin_d <= 1'b0;
        end else begin
            meta  <= dshotPin;
            pin_s <= meta;
            pin_d <= pin_s;
        end
    end

    assign rise = pin_s & ~pin_d;
    assign fall = ~pin_s & pin_d;

    // FSM and bit-assembly registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
            bcnt  <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            hcnt  <= hcnt_n;
            lcnt  <= lcnt_n;
            bcnt  <= bcnt_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic: pulse width measurement, bit shifting, abort paths
    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        lcnt_n  = lcnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        case (state)
            S_IDLE: begin
                bcnt_n = '0;
                if (rise) begin
                    hcnt_n  = '0;
                    state_n = S_HIGH;
                end
            end
            S_HIGH: begin
                hcnt_n = (hcnt == 8'hFF) ? hcnt : hcnt + 8'd1;
                if (fall) begin
                    if (hcnt < HMIN_C) begin
                        lcnt_n  = '0;
                        state_n = S_RESYNC;
                    end else begin
                        shreg_n = {shreg[14:0], (hcnt >= THRESH_C)};
                        bcnt_n  = bcnt + 5'd1;
                        if (bcnt == 5'd15) begin
                            state_n = S_CHECK;
                        end else begin
                            lcnt_n  = '0;
                            state_n = S_LOW;
                        end
                    end
                end else if (hcnt > HMAX_C) begin
                    lcnt_n  = '0;
                    state_n = S_RESYNC;
                end
            end
            S_LOW: begin
                if (rise) begin
                    hcnt_n  = '0;
                    state_n = S_HIGH;
                end else begin
                    lcnt_n = (lcnt == 8'hFF) ? lcnt : lcnt + 8'd1;
                    if (lcnt > GAP_C) begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_RESYNC: begin
                if (pin_s) begin
                    lcnt_n = '0;
                end else begin
                    lcnt_n = (lcnt == 8'hFF) ? lcnt : lcnt + 8'd1;
                    if (lcnt > GAP_C) begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_CHECK: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Frame field extraction, CRC and throttle-to-speed mapping
    always_comb begin
        rx_throttle = shreg[15:5];
        rx_telem    = shreg[4];
        rx_crc      = shreg[3:0];
        rx_v        = {rx_throttle, rx_telem};
        calc_crc    = rx_v[3:0] ^ rx_v[7:4] ^ rx_v[11:8];
        crc_ok      = (calc_crc == rx_crc);
        speed_diff  = rx_throttle - 11'd48;
        speed_new   = (rx_throttle < 11'd48) ? 8'd0 : speed_diff[10:3];
    end

    // Output registers, strobes and failsafe; a valid frame beats expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            throttle    <= '0;
            telem       <= 1'b0;
            outputSpeed <= '0;
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            link_ok     <= 1'b0;
            fs_cnt      <= '0;
        end else begin
            frame_valid <= 1'b0;
            crc_err     <= 1'b0;
            if ((state == S_CHECK) && crc_ok) begin
                throttle    <= rx_throttle;
                telem       <= rx_telem;
                outputSpeed <= speed_new;
                frame_valid <= 1'b1;
                link_ok     <= 1'b1;
                fs_cnt      <= FS_LOAD;
            end else begin
                if (state == S_CHECK) begin
                    crc_err <= 1'b1;
                end
                if (fs_cnt != '0) begin
                    fs_cnt <= fs_cnt - FS_ONE;
                    if (fs_cnt == FS_ONE) begin
                        link_ok     <= 1'b0;
                        outputSpeed <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dshot_frame_rx.sv
// Self-checking bench for dshot_frame_rx with a spec-level frame model.
module tb_dshot_frame_rx;

    localparam int FS = 1000;

    logic        clk;
    logic        rst_n;
    logic        pin;
    logic [10:0] throttle;
    logic        telem;
    logic [7:0]  outputSpeed;
    logic        frame_valid;
    logic        crc_err;
    logic        link_ok;

    int checks = 0;
    int errors = 0;
    int fv_n   = 0;
    int ce_n   = 0;

    dshot_frame_rx #(
        .BIT_THRESH(15),
        .HIGH_MIN(4),
        .HIGH_MAX(24),
        .GAP_CYCLES(40),
        .FAILSAFE_CYCLES(FS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .dshotPin(pin),
        .throttle(throttle),
        .telem(telem),
        .outputSpeed(outputSpeed),
        .frame_valid(frame_valid),
        .crc_err(crc_err),
        .link_ok(link_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe counters and mutual-exclusion check
    always @(negedge clk) begin
        if (frame_valid === 1'b1) fv_n++;
        if (crc_err === 1'b1) ce_n++;
        if (frame_valid === 1'b1 || crc_err === 1'b1) begin
            checks++;
            if (frame_valid === 1'b1 && crc_err === 1'b1) begin
                errors++;
                $display("FAIL strobe_exclusive got fv=%b ce=%b exp not both", frame_valid, crc_err);
            end
        end
    end

    function automatic logic [3:0] ref_crc(input logic [11:0] v);
        logic [11:0] x;
        x = v ^ (v >> 4) ^ (v >> 8);
        return x[3:0];
    endfunction

    function automatic logic [7:0] ref_speed(input int thr);
        if (thr < 48) return 8'd0;
        return 8'((thr - 48) / 8);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        int hi;
        hi = b ? int'($urandom_range(21, 18)) : int'($urandom_range(11, 8));
        pin = 1'b1;
        cyc(hi);
        pin = 1'b0;
        cyc(27 - hi);
    endtask

    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = 15; i > 15 - n; i--) send_bit(f[i]);
    endtask

    task automatic send_frame(input logic [15:0] f);
        send_bits(f, 16);
        cyc(60);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        pin   = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        checks++; if (throttle !== 11'd0) begin errors++; $display("FAIL reset_throttle got %0d exp 0", throttle); end
        checks++; if (telem !== 1'b0) begin errors++; $display("FAIL reset_telem got %b exp 0", telem); end
        checks++; if (outputSpeed !== 8'd0) begin errors++; $display("FAIL reset_speed got %0d exp 0", outputSpeed); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got %b exp 0", frame_valid); end
        checks++; if (crc_err !== 1'b0) begin errors++; $display("FAIL reset_ce got %b exp 0", crc_err); end
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL reset_link got %b exp 0", link_ok); end
    endtask

    task automatic test_basic;
        int fv0, ce0;
        fv0 = fv_n; ce0 = ce_n;
        send_frame(16'h830B);
        checks++; if (fv_n - fv0 !== 1) begin errors++; $display("FAIL basic_fv_count got %0d exp 1", fv_n - fv0); end
        checks++; if (ce_n - ce0 !== 0) begin errors++; $display("FAIL basic_ce_count got %0d exp 0", ce_n - ce0); end
        checks++; if (throttle !== 11'd1048) begin errors++; $display("FAIL basic_throttle got %0d exp 1048", throttle); end
        checks++; if (telem !== 1'b0) begin errors++; $display("FAIL basic_telem got %b exp 0", telem); end
        checks++; if (outputSpeed !== 8'd125) begin errors++; $display("FAIL basic_speed got %0d exp 125", outputSpeed); end
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL basic_link got %b exp 1", link_ok); end
    endtask

    task automatic test_extremes;
        int fv0;
        fv0 = fv_n;
        send_frame(16'hFFFF);
        checks++; if (fv_n - fv0 !== 1) begin errors++; $display("FAIL max_fv_count got %0d exp 1", fv_n - fv0); end
        checks++; if (throttle !== 11'd2047) begin errors++; $display("FAIL max_throttle got %0d exp 2047", throttle); end
        checks++; if (telem !== 1'b1) begin errors++; $display("FAIL max_telem got %b exp 1", telem); end
        checks++; if (outputSpeed !== 8'd249) begin errors++; $display("FAIL max_speed got %0d exp 249", outputSpeed); end
        send_frame(16'h0606);
        checks++; if (throttle !== 11'd48) begin errors++; $display("FAIL t48_throttle got %0d exp 48", throttle); end
        checks++; if (telem !== 1'b0) begin errors++; $display("FAIL t48_telem got %b exp 0", telem); end
        checks++; if (outputSpeed !== 8'd0) begin errors++; $display("FAIL t48_speed got %0d exp 0", outputSpeed); end
    endtask

    task automatic test_crc_err;
        int fv0, ce0;
        send_frame(16'h830B);
        fv0 = fv_n; ce0 = ce_n;
        send_frame(16'h830A);
        checks++; if (ce_n - ce0 !== 1) begin errors++; $display("FAIL crc_ce_count got %0d exp 1", ce_n - ce0); end
        checks++; if (fv_n - fv0 !== 0) begin errors++; $display("FAIL crc_fv_count got %0d exp 0", fv_n - fv0); end
        checks++; if (outputSpeed !== 8'd125) begin errors++; $display("FAIL crc_speed_hold got %0d exp 125", outputSpeed); end
        checks++; if (throttle !== 11'd1048) begin errors++; $display("FAIL crc_throttle_hold got %0d exp 1048", throttle); end
    endtask

    task automatic test_abort;
        int fv0, ce0;
        logic [15:0] f;
        f = 16'h830B;
        send_frame(16'hFFFF);
        fv0 = fv_n; ce0 = ce_n;
        send_bits(f, 8);
        cyc(100);
        send_frame(f);
        checks++; if (fv_n - fv0 !== 1) begin errors++; $display("FAIL gap_fv_count got %0d exp 1", fv_n - fv0); end
        checks++; if (ce_n - ce0 !== 0) begin errors++; $display("FAIL gap_ce_count got %0d exp 0", ce_n - ce0); end
        checks++; if (throttle !== 11'd1048) begin errors++; $display("FAIL gap_throttle got %0d exp 1048", throttle); end
        // Long pulse after 4 bits, then the remaining 11 bits: must all be ignored
        send_frame(16'hFFFF);
        fv0 = fv_n; ce0 = ce_n;
        send_bits(f, 4);
        pin = 1'b1; cyc(30); pin = 1'b0; cyc(7);
        for (int i = 10; i >= 0; i--) send_bit(f[i]);
        cyc(80);
        checks++; if (fv_n - fv0 !== 0) begin errors++; $display("FAIL long_fv_count got %0d exp 0", fv_n - fv0); end
        checks++; if (ce_n - ce0 !== 0) begin errors++; $display("FAIL long_ce_count got %0d exp 0", ce_n - ce0); end
        checks++; if (throttle !== 11'd2047) begin errors++; $display("FAIL long_throttle_hold got %0d exp 2047", throttle); end
        send_frame(f);
        checks++; if (fv_n - fv0 !== 1) begin errors++; $display("FAIL long_recover_fv got %0d exp 1", fv_n - fv0); end
    endtask

    task automatic test_failsafe;
        int k;
        send_bits(16'h830B, 15);
        pin = 1'b1; cyc(20); pin = 1'b0;
        k = 0;
        while (frame_valid !== 1'b1 && k < 20) begin
            cyc(1);
            k++;
        end
        checks++; if (k >= 20) begin errors++; $display("FAIL fs_strobe_wait got timeout exp frame_valid"); end
        cyc(FS - 1);
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL fs_link_before got %b exp 1", link_ok); end
        checks++; if (outputSpeed !== 8'd125) begin errors++; $display("FAIL fs_speed_before got %0d exp 125", outputSpeed); end
        cyc(1);
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL fs_link_after got %b exp 0", link_ok); end
        checks++; if (outputSpeed !== 8'd0) begin errors++; $display("FAIL fs_speed_after got %0d exp 0", outputSpeed); end
        checks++; if (throttle !== 11'd1048) begin errors++; $display("FAIL fs_throttle_hold got %0d exp 1048", throttle); end
        cyc(50);
        send_frame(16'h830B);
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL fs_link_restore got %b exp 1", link_ok); end
        checks++; if (outputSpeed !== 8'd125) begin errors++; $display("FAIL fs_speed_restore got %0d exp 125", outputSpeed); end
    endtask

    task automatic test_reset_mid;
        int fv0;
        send_frame(16'hFFFF);
        send_bits(16'hFFFF, 5);
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(1);
        checks++; if (throttle !== 11'd0) begin errors++; $display("FAIL rstmid_throttle got %0d exp 0", throttle); end
        checks++; if (telem !== 1'b0) begin errors++; $display("FAIL rstmid_telem got %b exp 0", telem); end
        checks++; if (outputSpeed !== 8'd0) begin errors++; $display("FAIL rstmid_speed got %0d exp 0", outputSpeed); end
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL rstmid_link got %b exp 0", link_ok); end
        cyc(60);
        fv0 = fv_n;
        send_frame(16'h830B);
        checks++; if (fv_n - fv0 !== 1) begin errors++; $display("FAIL rstmid_fv_count got %0d exp 1", fv_n - fv0); end
        checks++; if (throttle !== 11'd1048) begin errors++; $display("FAIL rstmid_next_throttle got %0d exp 1048", throttle); end
        checks++; if (outputSpeed !== 8'd125) begin errors++; $display("FAIL rstmid_next_speed got %0d exp 125", outputSpeed); end
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL rstmid_next_link got %b exp 1", link_ok); end
    endtask

    task automatic test_random;
        int          fv0, ce0, thr;
        logic        tel, bad, prev_bad, ok;
        logic [3:0]  crc;
        logic [15:0] f;
        logic [10:0] exp_thr;
        logic        exp_tel;
        logic [7:0]  exp_spd;
        exp_thr  = throttle === 11'd1048 ? 11'd1048 : 11'd0;
        send_frame(16'h830B);
        exp_thr  = 11'd1048; exp_tel = 1'b0; exp_spd = 8'd125;
        prev_bad = 1'b0;
        for (int n = 0; n < 24; n++) begin
            thr = ($urandom_range(3, 0) == 0) ? int'($urandom_range(60, 0)) : int'($urandom_range(2047, 0));
            tel = 1'($urandom_range(1, 0));
            crc = ref_crc({11'(thr), tel});
            bad = !prev_bad && ($urandom_range(2, 0) == 0);
            if (bad) crc = crc ^ 4'($urandom_range(15, 1));
            prev_bad = bad;
            f = {11'(thr), tel, crc};
            ok = (f[3:0] == ref_crc(f[15:4]));
            if (ok) begin
                exp_thr = 11'(thr);
                exp_tel = tel;
                exp_spd = ref_speed(thr);
            end
            fv0 = fv_n; ce0 = ce_n;
            send_frame(f);
            checks++; if (fv_n - fv0 !== (ok ? 1 : 0)) begin errors++; $display("FAIL rand%0d_fv f=%h got %0d exp %0d", n, f, fv_n - fv0, ok ? 1 : 0); end
            checks++; if (ce_n - ce0 !== (ok ? 0 : 1)) begin errors++; $display("FAIL rand%0d_ce f=%h got %0d exp %0d", n, f, ce_n - ce0, ok ? 0 : 1); end
            checks++; if (throttle !== exp_thr) begin errors++; $display("FAIL rand%0d_throttle f=%h got %0d exp %0d", n, f, throttle, exp_thr); end
            checks++; if (telem !== exp_tel) begin errors++; $display("FAIL rand%0d_telem f=%h got %b exp %b", n, f, telem, exp_tel); end
            checks++; if (outputSpeed !== exp_spd) begin errors++; $display("FAIL rand%0d_speed f=%h got %0d exp %0d", n, f, outputSpeed, exp_spd); end
            checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL rand%0d_link f=%h got %b exp 1", n, f, link_ok); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pin   = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_crc_err();
        test_abort();
        test_failsafe();
        test_reset_mid();
        test_random();
        cyc(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
